// File: rtl/sched_pkg.sv
// sched_pkg: shared constants and types for the hazard scheduler.
//   - stall-bus width, per-stage bit indices and the four stall encodings
//   - divide FSM state enum and default divide latency
//   - register-file addressing widths used by the load scoreboard
package sched_pkg;

    localparam int unsigned STALL_W   = 6;
    localparam int unsigned STALL_PC  = 0;
    localparam int unsigned STALL_IF  = 1;
    localparam int unsigned STALL_ID  = 2;
    localparam int unsigned STALL_EX  = 3;
    localparam int unsigned STALL_MEM = 4;
    localparam int unsigned STALL_WB  = 5;

    localparam logic [STALL_W-1:0] STALL_NONE     = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_FROM_ID  = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_FROM_EX  = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_FROM_MEM = 6'b011111;

    localparam int unsigned DIV_LAT_DEFAULT = 32;
    localparam int unsigned DIV_CNT_W       = 6;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/sched_scoreboard.sv
// sched_scoreboard: pending-load bit per architectural register.
//   clk, rst              clock, synchronous active-high reset
//   i_set_en, i_set_addr  issuing load marks its destination pending
//   i_clr_en, i_clr_addr  writeback retires the pending mark
//   i_rd_a_addr / o_rd_a_pend_c, i_rd_b_addr / o_rd_b_pend_c
//                         two combinational read ports
module sched_scoreboard
    import sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set_en,
    input  logic [REG_AW-1:0] i_set_addr,
    input  logic              i_clr_en,
    input  logic [REG_AW-1:0] i_clr_addr,
    input  logic [REG_AW-1:0] i_rd_a_addr,
    output logic              o_rd_a_pend_c,
    input  logic [REG_AW-1:0] i_rd_b_addr,
    output logic              o_rd_b_pend_c
);

    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_pend_nxt;

    // Set is applied after clear so a newer load to the same register wins;
    // $0 is hardwired and can never be pending.
    always_comb begin
        w_pend_nxt = r_pend;
        if (i_clr_en) w_pend_nxt[i_clr_addr] = 1'b0;
        if (i_set_en) w_pend_nxt[i_set_addr] = 1'b1;
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) r_pend <= '0;
        else     r_pend <= w_pend_nxt;
    end

    assign o_rd_a_pend_c = r_pend[i_rd_a_addr];
    assign o_rd_b_pend_c = r_pend[i_rd_b_addr];

endmodule

// File: rtl/hazard_sched.sv
// hazard_sched: pipeline hazard scheduler (load-use, multi-cycle divide,
// memory wait) producing the per-stage stall bus and the IF flush.
//   clk, rst                  clock, synchronous active-high reset
//   id_*                      decoded ID-stage instruction attributes
//   wb_we, wb_waddr           register-file writeback port
//   br_taken                  ID resolved a taken branch/jump
//   mem_stallreq              data SRAM not ready
//   stall[5:0]                hold per stage (PC,IF,ID,EX,MEM,WB), combinational
//   id_hold_inst              ID replays its latched instruction word
//   div_busy                  divide in progress
//   flush_if                  squash the IF/ID slot
// Build option: define HAZARD_DIV_SCHED_EN to include the divide FSM and
// counter; otherwise id_div is ignored and div_busy is tied low.
module hazard_sched
    import sched_pkg::*;
#(
    parameter int unsigned DIV_LAT = DIV_LAT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic               id_use_rs,
    input  logic               id_use_rt,
    input  logic               id_is_load,
    input  logic [REG_AW-1:0]  id_waddr,
    input  logic               id_div,
    input  logic               wb_we,
    input  logic [REG_AW-1:0]  wb_waddr,
    input  logic               br_taken,
    input  logic               mem_stallreq,
    output logic [STALL_W-1:0] stall,
    output logic               id_hold_inst,
    output logic               div_busy,
    output logic               flush_if
);

    logic w_rs_pend;
    logic w_rt_pend;
    logic w_stallreq_id;
    logic w_stallreq_ex;
    logic w_load_issue;
    logic r_hold;

    // A load only issues when ID actually advances.
    assign w_load_issue = id_valid & id_is_load & (id_waddr != '0) & ~stall[STALL_ID];

    sched_scoreboard u_sb (
        .clk           (clk),
        .rst           (rst),
        .i_set_en      (w_load_issue),
        .i_set_addr    (id_waddr),
        .i_clr_en      (wb_we),
        .i_clr_addr    (wb_waddr),
        .i_rd_a_addr   (id_rs),
        .o_rd_a_pend_c (w_rs_pend),
        .i_rd_b_addr   (id_rt),
        .o_rd_b_pend_c (w_rt_pend)
    );

    // Reads the registered pending bits, so a same-cycle WB does not release it.
    assign w_stallreq_id = id_valid & ((id_use_rs & w_rs_pend) | (id_use_rt & w_rt_pend));

    // Stall bus priority: MEM wait, then divide, then load-use.
    always_comb begin
        stall = STALL_NONE;
        if (mem_stallreq)       stall = STALL_FROM_MEM;
        else if (w_stallreq_ex) stall = STALL_FROM_EX;
        else if (w_stallreq_id) stall = STALL_FROM_ID;
    end

    // ID replays its word after a cycle where it was held but EX moved on.
    always_ff @(posedge clk) begin
        if (rst) r_hold <= 1'b0;
        else     r_hold <= stall[STALL_ID] & ~stall[STALL_EX];
    end
    assign id_hold_inst = r_hold;

    // A branch seen under an ID stall is re-presented by ID when it releases.
    assign flush_if = br_taken & ~stall[STALL_ID];

`ifdef HAZARD_DIV_SCHED_EN
    div_state_e           r_state;
    div_state_e           w_state_nxt;
    logic [DIV_CNT_W-1:0] r_cnt;
    logic [DIV_CNT_W-1:0] w_cnt_nxt;
    logic                 w_div_issue;

    assign w_div_issue = id_valid & id_div & ~stall[STALL_ID];

    // Divide FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Divide FSM next state; the counter freezes while MEM is held.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_div_issue) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = DIV_CNT_W'(DIV_LAT - 1);
                end
            end
            BUSY: begin
                if (!stall[STALL_MEM]) begin
                    if (r_cnt == '0) w_state_nxt = DONE;
                    else             w_cnt_nxt   = r_cnt - DIV_CNT_W'(1);
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Divide FSM outputs.
    always_comb begin
        div_busy = 1'b0;
        if (r_state == BUSY) div_busy = 1'b1;
    end

    assign w_stallreq_ex = div_busy;
`else
    logic [DIV_CNT_W:0] w_unused_cfg;

    assign w_unused_cfg  = {id_div, DIV_CNT_W'(DIV_LAT)};
    assign div_busy      = 1'b0;
    assign w_stallreq_ex = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// tb_hazard_sched: directed scoreboard bench for hazard_sched.
// Expected outputs are queued as each step's inputs are driven and popped at
// the following falling edge when the DUT outputs are sampled.
module tb_hazard_sched;

    localparam int unsigned TB_DIV_LAT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_is_load;
    logic [4:0] id_waddr;
    logic       id_div;
    logic       wb_we;
    logic [4:0] wb_waddr;
    logic       br_taken;
    logic       mem_stallreq;
    logic [5:0] stall;
    logic       id_hold_inst;
    logic       div_busy;
    logic       flush_if;

    always #5 clk = ~clk;

    hazard_sched #(.DIV_LAT(TB_DIV_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_is_load   (id_is_load),
        .id_waddr     (id_waddr),
        .id_div       (id_div),
        .wb_we        (wb_we),
        .wb_waddr     (wb_waddr),
        .br_taken     (br_taken),
        .mem_stallreq (mem_stallreq),
        .stall        (stall),
        .id_hold_inst (id_hold_inst),
        .div_busy     (div_busy),
        .flush_if     (flush_if)
    );

    typedef struct {
        string       tag;
        logic [5:0]  stall;
        logic        hold;
        logic        busy;
        logic        flush;
        logic [31:0] pend;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s.%s: observed %h expected %h", tag, fld, obs, exp);
        end
    endtask

    task automatic clr_in();
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_is_load = 1'b0; id_waddr = '0; id_div = 1'b0; wb_we = 1'b0; wb_waddr = '0;
        br_taken = 1'b0; mem_stallreq = 1'b0; rst = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [5:0] s, input logic h,
                              input logic b, input logic f, input logic [31:0] p);
        exp_t e;
        e.tag = tag; e.stall = s; e.hold = h; e.busy = b; e.flush = f; e.pend = p;
        exp_q.push_back(e);
    endtask

    // Sample at the falling edge, compare against the queued entry, then
    // advance past the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL queue: observed empty expected entry");
        end else begin
            e = exp_q.pop_front();
            chk(e.tag, "stall", 32'(stall), 32'(e.stall));
            chk(e.tag, "hold",  32'(id_hold_inst), 32'(e.hold));
            chk(e.tag, "busy",  32'(div_busy), 32'(e.busy));
            chk(e.tag, "flush", 32'(flush_if), 32'(e.flush));
            chk(e.tag, "pend",  dut.u_sb.r_pend, e.pend);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] rd);
        id_valid = 1'b1; id_is_load = 1'b1; id_waddr = rd;
    endtask

    task automatic use_rs(input logic [4:0] r);
        id_valid = 1'b1; id_use_rs = 1'b1; id_rs = r;
    endtask

    initial begin
        clr_in();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset state
        clr_in(); expect_out("rst", 6'h00, 0, 0, 0, 32'h0); tick();

        // Load-use on $5 held until WB, then one replay cycle
        clr_in(); load(5);                  expect_out("lu_ld",   6'h00, 0, 0, 0, 32'h0);  tick();
        clr_in(); use_rs(5);                expect_out("lu_st1",  6'h07, 0, 0, 0, 32'h20); tick();
        clr_in(); use_rs(5); wb_we = 1'b1; wb_waddr = 5;
                                            expect_out("lu_wbsame", 6'h07, 1, 0, 0, 32'h20); tick();
        clr_in(); use_rs(5);                expect_out("lu_rel",  6'h00, 1, 0, 0, 32'h0);  tick();
        clr_in();                           expect_out("lu_idle", 6'h00, 0, 0, 0, 32'h0);  tick();

        // $0 is never tracked
        clr_in(); load(0);                  expect_out("r0_ld",  6'h00, 0, 0, 0, 32'h0); tick();
        clr_in(); use_rs(0); id_use_rt = 1'b1;
                                            expect_out("r0_use", 6'h00, 0, 0, 0, 32'h0); tick();

        // Same-cycle set and clear: the newer load wins
        clr_in(); load(7);                  expect_out("sc_ld1", 6'h00, 0, 0, 0, 32'h0);  tick();
        clr_in(); load(7); wb_we = 1'b1; wb_waddr = 7;
                                            expect_out("sc_ld2", 6'h00, 0, 0, 0, 32'h80); tick();
        clr_in(); wb_we = 1'b1; wb_waddr = 7;
                                            expect_out("sc_wb",  6'h00, 0, 0, 0, 32'h80); tick();
        clr_in();                           expect_out("sc_clr", 6'h00, 0, 0, 0, 32'h0);  tick();

        // rt port, unused sources, invalid ID
        clr_in(); load(9);                  expect_out("rt_ld",   6'h00, 0, 0, 0, 32'h0);   tick();
        clr_in(); id_valid = 1'b1; id_rs = 9; id_rt = 9;
                                            expect_out("rt_nouse", 6'h00, 0, 0, 0, 32'h200); tick();
        clr_in(); id_valid = 1'b1; id_rt = 9; id_use_rt = 1'b1;
                                            expect_out("rt_use",  6'h07, 0, 0, 0, 32'h200); tick();
        clr_in(); id_rt = 9; id_use_rt = 1'b1; wb_we = 1'b1; wb_waddr = 9;
                                            expect_out("rt_inval", 6'h00, 1, 0, 0, 32'h200); tick();
        clr_in();                           expect_out("rt_idle", 6'h00, 0, 0, 0, 32'h0);   tick();

        // A stalled load must not issue
        clr_in(); load(5);                  expect_out("sl_ld5", 6'h00, 0, 0, 0, 32'h0);  tick();
        clr_in(); load(6); use_rs(5);       expect_out("sl_st1", 6'h07, 0, 0, 0, 32'h20); tick();
        clr_in(); load(6); use_rs(5); wb_we = 1'b1; wb_waddr = 5;
                                            expect_out("sl_st2", 6'h07, 1, 0, 0, 32'h20); tick();
        clr_in(); load(6); use_rs(5);       expect_out("sl_iss", 6'h00, 1, 0, 0, 32'h0);  tick();
        clr_in(); wb_we = 1'b1; wb_waddr = 6;
                                            expect_out("sl_set6", 6'h00, 0, 0, 0, 32'h40); tick();
        clr_in();                           expect_out("sl_idle", 6'h00, 0, 0, 0, 32'h0);  tick();

        // Branch deferred behind a load-use stall
        clr_in(); load(5);                  expect_out("br_ld",  6'h00, 0, 0, 0, 32'h0);  tick();
        clr_in(); use_rs(5); br_taken = 1'b1;
                                            expect_out("br_st1", 6'h07, 0, 0, 0, 32'h20); tick();
        clr_in(); use_rs(5); br_taken = 1'b1; wb_we = 1'b1; wb_waddr = 5;
                                            expect_out("br_st2", 6'h07, 1, 0, 0, 32'h20); tick();
        clr_in(); use_rs(5); br_taken = 1'b1;
                                            expect_out("br_fl",  6'h00, 1, 0, 1, 32'h0);  tick();
        clr_in();                           expect_out("br_end", 6'h00, 0, 0, 0, 32'h0);  tick();

        // MEM wait dominates; no replay because EX is also held
        clr_in(); mem_stallreq = 1'b1; br_taken = 1'b1;
                                            expect_out("mem_st",  6'h1f, 0, 0, 0, 32'h0); tick();
        clr_in();                           expect_out("mem_rel", 6'h00, 0, 0, 0, 32'h0); tick();

        // Reset beats a simultaneous load issue
        clr_in(); load(4); rst = 1'b1;      expect_out("rst_ld",  6'h00, 0, 0, 0, 32'h0); tick();
        clr_in();                           expect_out("rst_ld2", 6'h00, 0, 0, 0, 32'h0); tick();

`ifdef HAZARD_DIV_SCHED_EN
        // Divide: exactly DIV_LAT busy cycles, then DONE, then IDLE
        clr_in(); id_valid = 1'b1; id_div = 1'b1;
                                            expect_out("dv_iss", 6'h00, 0, 0, 0, 32'h0); tick();
        for (int i = 0; i < int'(TB_DIV_LAT); i++) begin
            clr_in();                       expect_out($sformatf("dv_busy%0d", i), 6'h0f, 0, 1, 0, 32'h0); tick();
        end
        clr_in();                           expect_out("dv_done", 6'h00, 0, 0, 0, 32'h0); tick();
        clr_in();                           expect_out("dv_idle", 6'h00, 0, 0, 0, 32'h0); tick();

        // Divide frozen by MEM wait for two cycles
        clr_in(); id_valid = 1'b1; id_div = 1'b1;
                                            expect_out("dm_iss", 6'h00, 0, 0, 0, 32'h0); tick();
        clr_in();                           expect_out("dm_b0",  6'h0f, 0, 1, 0, 32'h0); tick();
        clr_in(); mem_stallreq = 1'b1;      expect_out("dm_m0",  6'h1f, 0, 1, 0, 32'h0); tick();
        clr_in(); mem_stallreq = 1'b1;      expect_out("dm_m1",  6'h1f, 0, 1, 0, 32'h0); tick();
        clr_in();                           expect_out("dm_b1",  6'h0f, 0, 1, 0, 32'h0); tick();
        clr_in();                           expect_out("dm_b2",  6'h0f, 0, 1, 0, 32'h0); tick();
        clr_in();                           expect_out("dm_b3",  6'h0f, 0, 1, 0, 32'h0); tick();
        clr_in();                           expect_out("dm_done", 6'h00, 0, 0, 0, 32'h0); tick();

        // Reset aborts a divide in BUSY and clears the scoreboard
        clr_in(); load(3);                  expect_out("dr_ld",  6'h00, 0, 0, 0, 32'h0); tick();
        clr_in(); id_valid = 1'b1; id_div = 1'b1;
                                            expect_out("dr_iss", 6'h00, 0, 0, 0, 32'h8); tick();
        clr_in();                           expect_out("dr_b0",  6'h0f, 0, 1, 0, 32'h8); tick();
        clr_in(); rst = 1'b1;               expect_out("dr_rst", 6'h0f, 0, 1, 0, 32'h8); tick();
        clr_in();                           expect_out("dr_post0", 6'h00, 0, 0, 0, 32'h0); tick();
        clr_in();                           expect_out("dr_post1", 6'h00, 0, 0, 0, 32'h0); tick();
`else
        // Divide disabled: id_div has no effect
        clr_in(); id_valid = 1'b1; id_div = 1'b1;
                                            expect_out("nd_iss",  6'h00, 0, 0, 0, 32'h0); tick();
        clr_in();                           expect_out("nd_post", 6'h00, 0, 0, 0, 32'h0); tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
